// File: rtl/divide_by_n_fsm_if.sv
// Control/status bundle for the divide-by-N generator.
// master drives the control side; slave is the divider itself.
interface divide_by_n_fsm_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] div_in;
  logic             mode;
  logic             y;
  logic [WIDTH-1:0] count;
  logic             wrap;

  modport master (
    output en, load, div_in, mode,
    input  y, count, wrap
  );

  modport slave (
    input  en, load, div_in, mode,
    output y, count, wrap
  );
endinterface

// File: rtl/divide_by_n_fsm.sv
// Programmable divide-by-N: a modulo-N state counter with pulse or
// near-50% square-wave output shapes, selected at load time.
module divide_by_n_fsm #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input logic              clk,
  input logic              reset,
  divide_by_n_fsm_if.slave bus
);

  typedef enum logic {
    PULSE  = 1'b0,
    SQUARE = 1'b1
  } mode_e;

  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] count_r;
  mode_e            mode_r;

  logic [WIDTH-1:0] last;
  logic             at_last;
  logic [WIDTH:0]   half;

  // div_r is never 0, so the terminal index never underflows
  assign last    = div_r - WIDTH'(1);
  assign at_last = (count_r == last);
  // one extra bit so ceil(N/2) of the largest divisor does not overflow
  assign half    = ({1'b0, div_r} + (WIDTH+1)'(1)) >> 1;

  // state update: reset beats load, load beats en; zero divisor treated as 1
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
      div_r   <= WIDTH'(DEFAULT_DIV);
      mode_r  <= PULSE;
    end else if (bus.load) begin
      div_r   <= (bus.div_in == '0) ? WIDTH'(1) : bus.div_in;
      mode_r  <= mode_e'(bus.mode);
      count_r <= '0;
    end else if (bus.en) begin
      count_r <= at_last ? '0 : count_r + WIDTH'(1);
    end
  end

  // output shape decoded from registered state only
  always_comb begin
    bus.y = 1'b0;
    case (mode_r)
      PULSE:   bus.y = (count_r == '0);
      SQUARE:  bus.y = ({1'b0, count_r} < half);
      default: bus.y = 1'b0;
    endcase
  end

  assign bus.count = count_r;
  // edge that returns count to 0; a load in the same cycle suppresses it
  assign bus.wrap  = bus.en & ~bus.load & at_last;

endmodule

// File: tb/tb_divide_by_n_fsm.sv
// Self-checking bench: directed literal sequences plus randomized traffic,
// all compared against a modulo-arithmetic reference model.
module tb_divide_by_n_fsm;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 0;

  divide_by_n_fsm_if #(.WIDTH(WIDTH)) bus ();

  divide_by_n_fsm #(.WIDTH(WIDTH), .DEFAULT_DIV(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // reference model: divisor, shape, position within period
  int m_div  = 3;
  int m_mode = 0;
  int m_cnt  = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_div  <= 3;
      m_mode <= 0;
      m_cnt  <= 0;
    end else if (bus.load) begin
      m_div  <= (bus.div_in == 0) ? 1 : int'(bus.div_in);
      m_mode <= int'(bus.mode);
      m_cnt  <= 0;
    end else if (bus.en) begin
      m_cnt  <= (m_cnt + 1) % m_div;
    end
  end

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      int ey, ew;
      ey = (m_mode != 0) ? int'(2 * m_cnt < m_div) : int'(m_cnt == 0);
      ew = int'(bus.en && !bus.load && ((m_cnt + 1) % m_div == 0));
      check("model_count", int'(bus.count), m_cnt);
      check("model_y",     int'(bus.y),     ey);
      check("model_wrap",  int'(bus.wrap),  ew);
    end
  end

  // drive one cycle's inputs just after the edge, then settle to negedge
  task automatic step(input bit e, input bit l, input int d, input bit m, input bit r);
    @(posedge clk);
    #1;
    bus.en     = e;
    bus.load   = l;
    bus.div_in = WIDTH'(d);
    bus.mode   = m;
    reset      = r;
    @(negedge clk);
  endtask

  // hand-computed expectation for the current cycle
  task automatic pin(input string name, input int c, input int y, input int w);
    check({name, "_count"}, int'(bus.count), c);
    check({name, "_y"},     int'(bus.y),     y);
    check({name, "_wrap"},  int'(bus.wrap),  w);
  endtask

  initial begin
    bus.en = 0; bus.load = 0; bus.div_in = '0; bus.mode = 0; reset = 1;

    // reset state
    step(0, 0, 0, 0, 1);
    chk_en = 1;
    step(0, 0, 0, 0, 0);
    pin("reset", 0, 1, 0);

    // default divide-by-3 pulse
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 0);
      pin("div3", i % 3, int'(i % 3 == 0), int'(i % 3 == 2));
    end

    // N=5 pulse
    step(0, 1, 5, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0);
      pin("div5_pulse", i % 5, int'(i % 5 == 0), int'(i % 5 == 4));
    end

    // N=5 square: 1,1,1,0,0
    step(0, 1, 5, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0);
      pin("div5_sq", i % 5, int'(i % 5 < 3), int'(i % 5 == 4));
    end

    // N=4 square: 1,1,0,0
    step(0, 1, 4, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0, 0);
      pin("div4_sq", i % 4, int'(i % 4 < 2), int'(i % 4 == 3));
    end

    // reload with the same divisor mid-period restarts the count
    step(1, 1, 4, 1, 0);
    step(1, 0, 0, 0, 0);
    pin("same_div_reload", 0, 1, 0);

    // div_in 0 and 1 both behave as divide-by-1
    for (int k = 0; k < 2; k++) begin
      step(0, 1, k, k, 0);
      for (int i = 0; i < 4; i++) begin
        step(1, 0, 0, 0, 0);
        pin("div1", 0, 1, 1);
      end
    end

    // N=6 with en gaps, then reload N=4 at count 3
    step(0, 1, 6, 0, 0);
    step(1, 0, 0, 0, 0); pin("hold_a", 0, 1, 0);
    step(0, 0, 0, 0, 0); pin("hold_b", 1, 0, 0);
    step(0, 0, 0, 0, 0); pin("hold_c", 1, 0, 0);
    step(1, 0, 0, 0, 0); pin("hold_d", 1, 0, 0);
    step(1, 0, 0, 0, 0); pin("hold_e", 2, 0, 0);
    step(1, 1, 4, 0, 0); pin("reload_at3", 3, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0, 0);
      pin("after_reload4", i % 4, int'(i % 4 == 0), int'(i % 4 == 3));
    end

    // maximum divisor: terminal count 254, then reset at count 100
    step(0, 1, 255, 0, 0);
    for (int i = 0; i < 256; i++) begin
      step(1, 0, 0, 0, 0);
      if (i == 254) pin("max_terminal", 254, 0, 1);
      if (i == 255) pin("max_wrapped", 0, 1, 0);
    end
    for (int i = 1; i < 100; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    pin("at100", 100, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 0);
      pin("post_reset", i % 3, int'(i % 3 == 0), int'(i % 3 == 2));
    end

    // randomized traffic checked by the model
    for (int i = 0; i < 4000; i++) begin
      int d;
      case ($urandom_range(0, 5))
        0:       d = $urandom_range(0, 1);
        1:       d = $urandom_range(250, 255);
        default: d = $urandom_range(2, 12);
      endcase
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0,
           d,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 127) == 0);
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
